// File: rtl/inst_ram_loader_pkg.sv
// Shared types and constants for the instruction RAM boot loader.
package inst_ram_loader_pkg;
    localparam int          DEF_W     = 32;
    localparam int          DEF_H     = 8;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CSUM   = 3'd2,
        S_VERIFY = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;
endpackage

// File: rtl/inst_ram_loader_acc.sv
// Clearable modular accumulator; nxt exposes the would-be sum for same-cycle compares.
module ram_csum_acc #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] nxt
);
    assign nxt = q + d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (clr) q <= '0;
        else if (en)  q <= nxt;
    end
endmodule

// File: rtl/inst_ram_loader.sv
// Boot loader: streams a program into instruction RAM, checks its checksum,
// reads it back to verify, then hands the RAM read port to the core.
module inst_ram_loader
    import inst_ram_loader_pkg::*;
#(
    parameter int          W   = DEF_W,
    parameter int          H   = DEF_H,
    parameter logic [W-1:0] NOP = W'(NOP_INSTR)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [H:0]   len,
    input  logic         s_valid,
    input  logic [W-1:0] s_data,
    output logic         s_ready,
    input  logic [W-1:0] core_pc,
    input  logic         core_re,
    output logic [W-1:0] core_inst,
    output logic         core_hold,
    output logic [W-1:0] ram_pc,
    output logic         ram_re,
    input  logic [W-1:0] ram_rdata,
    output logic         ram_we,
    output logic [W-1:0] ram_waddr,
    output logic [W-1:0] ram_wdata,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam logic [H:0] MAX_LEN = {1'b1, {H{1'b0}}};

    state_t       state;
    logic [H:0]   idx, len_q;
    logic [W-1:0] sum, sum_nxt, vsum, vsum_nxt;
    logic         hs, idle_like, start_ok, len_bad, last;

    assign hs        = s_valid && s_ready;
    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
    assign start_ok  = start && idle_like;
    assign len_bad   = (len == '0) || (len > MAX_LEN);
    assign last      = (idx == len_q - (H+1)'(1));

    ram_csum_acc #(.W(W)) u_sum (
        .clk(clk), .rst_n(rst_n), .clr(start_ok && !len_bad),
        .en(hs && state == S_LOAD), .d(s_data), .q(sum), .nxt(sum_nxt)
    );

    ram_csum_acc #(.W(W)) u_vsum (
        .clk(clk), .rst_n(rst_n), .clr(start_ok && !len_bad),
        .en(state == S_VERIFY), .d(ram_rdata), .q(vsum), .nxt(vsum_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
            len_q <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        if (len_bad) begin
                            state <= S_ERROR;
                        end else begin
                            len_q <= len;
                            idx   <= '0;
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (hs) begin
                        idx <= last ? '0 : idx + (H+1)'(1);
                        if (last) state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (hs) state <= (s_data == sum) ? S_VERIFY : S_ERROR;
                end
                S_VERIFY: begin
                    idx <= idx + (H+1)'(1);
                    // vsum_nxt already includes the word being read this cycle
                    if (last) state <= (vsum_nxt == sum) ? S_DONE : S_ERROR;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        s_ready   = (state == S_LOAD) || (state == S_CSUM);
        ram_we    = (state == S_LOAD) && s_valid;
        ram_waddr = W'(idx) << 2;
        ram_wdata = s_data;
        ram_re    = 1'b0;
        ram_pc    = '0;
        core_inst = NOP;
        core_hold = 1'b1;
        busy      = (state == S_LOAD) || (state == S_CSUM) || (state == S_VERIFY);
        done      = (state == S_DONE);
        err       = (state == S_ERROR);
        if (state == S_VERIFY) begin
            ram_re = 1'b1;
            ram_pc = W'(idx) << 2;
        end else if (state == S_DONE) begin
            ram_re    = core_re;
            ram_pc    = core_pc;
            core_inst = ram_rdata;
            core_hold = 1'b0;
        end
    end
endmodule

// File: tb/tb_inst_ram_loader.sv
// Randomized scoreboard bench for inst_ram_loader with a behavioural RAM.
module tb_inst_ram_loader;
    localparam int W = 32;
    localparam int H = 8;
    localparam logic [31:0] NOPV = 32'h0000_0013;

    logic         clk = 0, rst_n = 0, start = 0, s_valid = 0, core_re = 0;
    logic [H:0]   len = '0;
    logic [W-1:0] s_data = '0, core_pc = '0;
    logic         s_ready, core_hold, ram_re, ram_we, busy, done, err;
    logic [W-1:0] core_inst, ram_pc, ram_rdata, ram_waddr, ram_wdata;

    logic [W-1:0] mem   [0:(1<<H)-1];
    logic [W-1:0] model [0:(1<<H)-1];

    typedef struct { logic [W-1:0] addr; logic [W-1:0] data; } wr_t;
    wr_t wq[$];

    int checks = 0, errors = 0;

    inst_ram_loader #(.W(W), .H(H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .core_pc(core_pc), .core_re(core_re), .core_inst(core_inst),
        .core_hold(core_hold), .ram_pc(ram_pc), .ram_re(ram_re),
        .ram_rdata(ram_rdata), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_wdata(ram_wdata), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_pc[H+1:2]];
    always @(posedge clk) if (ram_we) mem[ram_waddr[H+1:2]] <= ram_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the next expected stream word
    always @(negedge clk) begin
        if (rst_n && ram_we) begin
            if (wq.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = wq.pop_front();
                check("write_addr", ram_waddr, e.addr);
                check("write_data", ram_wdata, e.data);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hold"}, core_hold, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_ready"}, s_ready, 0);
        check({tag, "_we"}, ram_we, 0);
        check({tag, "_re"}, ram_re, 0);
        check({tag, "_inst"}, core_inst, NOPV);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic send_start(input int n);
        @(posedge clk); #1;
        start = 1; len = n[H:0];
        @(posedge clk); #1;
        start = 0;
    endtask

    // mode: 0 random words, 1 counting 1..n, 2 constant 5
    task automatic run_load(input int n, input int mode, input bit good,
                            input bit gaps, input bit poke);
        logic [W-1:0] d, s;
        int c;
        s = '0;
        send_start(n);
        check("busy_after_start", busy, 1);
        check("done_clear_on_start", done, 0);
        check("err_clear_on_start", err, 0);
        for (int i = 0; i < n; i++) begin
            d = (mode == 1) ? W'(i + 1) : (mode == 2) ? 32'd5 : $urandom;
            s += d;
            model[i] = d;
            wq.push_back('{addr: W'(i * 4), data: d});
            s_valid = 1; s_data = d;
            if (poke && i == 1) begin start = 1; len = 9'd1; end
            @(posedge clk); #1;
            s_valid = 0; start = 0;
            if (gaps) begin repeat (2) @(posedge clk); #1; end
        end
        check("csum_ready", s_ready, 1);
        s_valid = 1; s_data = good ? s : s ^ 32'h3;
        @(posedge clk); #1;
        s_valid = 0;
        c = 0;
        while (!done && !err && c < 2 * n + 8) begin
            if (poke && c == 1) start = 1;
            @(posedge clk); #1;
            start = 0;
            c++;
        end
        check("outcome_done", done, good);
        check("outcome_err", err, !good);
        check("verify_cycles", c, good ? n : 0);
        check("core_hold", core_hold, !good);
        if (good) begin
            for (int r = 0; r < 4; r++) begin
                int k;
                k = (r == 0 && n > 1) ? 1 : $urandom_range(0, n - 1);
                core_re = 1; core_pc = W'(k * 4);
                #1;
                check("core_fetch", core_inst, model[k]);
                check("ram_re_pass", ram_re, 1);
            end
            core_re = 0;
        end else begin
            core_re = 1; core_pc = 32'd0;
            #1;
            check("err_inst_nop", core_inst, NOPV);
            check("err_ram_re", ram_re, 0);
            core_re = 0;
        end
    endtask

    task automatic run_bad_len(input int n);
        send_start(n);
        check("badlen_err", err, 1);
        check("badlen_busy", busy, 0);
        check("badlen_hold", core_hold, 1);
    endtask

    initial begin
        #1;
        check_reset_outputs("reset");
        #20 rst_n = 1;

        run_load(3, 1, 1, 0, 0);
        run_load(2, 2, 0, 0, 0);
        check("bad_csum_mem0", mem[0], 32'd5);
        check("bad_csum_mem1", mem[1], 32'd5);
        run_load(4, 0, 1, 1, 0);
        run_bad_len(0);
        run_bad_len(257);
        run_load(5, 0, 1, 0, 1);
        run_load(6, 0, 1, 0, 0);
        for (int t = 0; t < 4; t++)
            run_load($urandom_range(1, 20), 0, ($urandom_range(0, 3) != 0), t[0], 0);
        run_load(1 << H, 0, 1, 0, 0);

        // reset in the middle of a load
        send_start(4);
        for (int i = 0; i < 2; i++) begin
            s_data = $urandom;
            wq.push_back('{addr: W'(i * 4), data: s_data});
            s_valid = 1;
            @(posedge clk); #1;
            s_valid = 0;
        end
        #2 rst_n = 0;
        #1;
        check_reset_outputs("midreset");
        #10 rst_n = 1;
        run_load(4, 0, 1, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        check("write_queue_drained", wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
